// File: rtl/layer_sequencer.sv
// Runs the layer engines one after another on the shared datapath bus.
// For each layer it pulses a local reset, enables the layer, waits for its done flag, and watches for a timeout.
module layer_sequencer #(
  parameter int N_LAYERS   = 3,
  parameter int SEL_W      = 2,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 4096,
  parameter int TO_W       = 13
) (
  input  logic                clk,
  input  logic                iRst_n,
  input  logic                iStart,
  input  logic                iAbort,
  input  logic [N_LAYERS-1:0] iLayerDone,
  input  logic [N_LAYERS-1:0] iLayerOvf,
  output logic [N_LAYERS-1:0] oLayerEna,
  output logic [N_LAYERS-1:0] oLayerRst_n,
  output logic [SEL_W-1:0]    oSel,
  output logic                oBusy,
  output logic                oDone,
  output logic                oOverflow,
  output logic                oTimeout,
  output logic [SEL_W-1:0]    oErrLayer
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [N_LAYERS-1:0] ONE = N_LAYERS'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_RUN,
    ST_NEXT,
    ST_DONE,
    ST_ERROR
  } state_t;

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    idx, idx_nxt;
  logic [RC_W-1:0]     rcnt, rcnt_nxt;
  logic [TO_W-1:0]     wdog, wdog_nxt;
  logic                ovf, ovf_nxt;
  logic [SEL_W-1:0]    errl, errl_nxt;
  logic [SEL_W-1:0]    sel, sel_nxt;
  logic [N_LAYERS-1:0] ena_nxt, rstn_nxt;
  logic                busy_nxt, done_nxt, to_nxt;
  logic                busy_now;

  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      rcnt        <= '0;
      wdog        <= '0;
      ovf         <= 1'b0;
      errl        <= '0;
      sel         <= '0;
      oLayerEna   <= '0;
      oLayerRst_n <= '1;
      oBusy       <= 1'b0;
      oDone       <= 1'b0;
      oTimeout    <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      rcnt        <= rcnt_nxt;
      wdog        <= wdog_nxt;
      ovf         <= ovf_nxt;
      errl        <= errl_nxt;
      sel         <= sel_nxt;
      oLayerEna   <= ena_nxt;
      oLayerRst_n <= rstn_nxt;
      oBusy       <= busy_nxt;
      oDone       <= done_nxt;
      oTimeout    <= to_nxt;
    end
  end

  assign busy_now = (state == ST_RESET) || (state == ST_RUN) || (state == ST_NEXT);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    rcnt_nxt  = rcnt;
    wdog_nxt  = wdog;
    ovf_nxt   = ovf;
    errl_nxt  = errl;
    sel_nxt   = sel;
    if (iAbort && busy_now) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (iStart && iAbort) begin
            state_nxt = ST_IDLE;
          end else if (iStart) begin
            state_nxt = ST_RESET;
            idx_nxt   = '0;
            rcnt_nxt  = '0;
            ovf_nxt   = 1'b0;
            errl_nxt  = '0;
            sel_nxt   = '0;
          end
        end
        ST_RESET: begin
          if (rcnt == RC_W'(RST_CYCLES - 1)) begin
            state_nxt = ST_RUN;
            wdog_nxt  = '0;
          end else begin
            rcnt_nxt = rcnt + RC_W'(1);
          end
        end
        ST_RUN: begin
          wdog_nxt = wdog + TO_W'(1);
          // Done takes precedence over a watchdog expiry on the same edge.
          if (iLayerDone[idx]) begin
            state_nxt = ST_NEXT;
            ovf_nxt   = ovf | iLayerOvf[idx];
          end else if (wdog == TO_W'(TIMEOUT - 1)) begin
            state_nxt = ST_ERROR;
            errl_nxt  = idx;
          end
        end
        ST_NEXT: begin
          if (idx == SEL_W'(N_LAYERS - 1)) begin
            state_nxt = ST_DONE;
          end else begin
            state_nxt = ST_RESET;
            idx_nxt   = idx + SEL_W'(1);
            sel_nxt   = idx + SEL_W'(1);
            rcnt_nxt  = '0;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    ena_nxt  = '0;
    rstn_nxt = '1;
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    to_nxt   = 1'b0;
    case (state_nxt)
      ST_RESET: begin
        ena_nxt  = ONE << idx_nxt;
        rstn_nxt = ~(ONE << idx_nxt);
        busy_nxt = 1'b1;
      end
      ST_RUN: begin
        ena_nxt  = ONE << idx_nxt;
        busy_nxt = 1'b1;
      end
      ST_NEXT:  busy_nxt = 1'b1;
      ST_DONE:  done_nxt = 1'b1;
      ST_ERROR: to_nxt   = 1'b1;
      default:  ;
    endcase
  end

  assign oSel      = sel;
  assign oOverflow = ovf;
  assign oErrLayer = errl;

endmodule

// File: tb/tb_layer_sequencer.sv
// Randomised bench for layer_sequencer: behavioural layer engines plus a per-cycle expected-output trace
// built from per-layer latencies and overflow values.
module tb_layer_sequencer;

  localparam int N  = 3;
  localparam int RC = 2;
  localparam int TO = 16;

  typedef struct packed {
    logic [N-1:0] ena;
    logic [N-1:0] rstn;
    logic [1:0]   sel;
    logic         busy;
    logic         done;
    logic         ovf;
    logic         to;
    logic [1:0]   errl;
  } vec_t;

  logic         clk = 1'b0;
  logic         iRst_n, iStart, iAbort;
  logic [N-1:0] iLayerDone, iLayerOvf;
  logic [N-1:0] oLayerEna, oLayerRst_n;
  logic [1:0]   oSel, oErrLayer;
  logic         oBusy, oDone, oOverflow, oTimeout;

  int unsigned total = 0;
  int unsigned bad   = 0;

  int unsigned lat [N];
  logic        ovf_val [N];
  int unsigned cnt [N];
  logic        junk [N];
  vec_t        exp_q [$];

  layer_sequencer #(
    .N_LAYERS  (N),
    .SEL_W     (2),
    .RST_CYCLES(RC),
    .TIMEOUT   (TO),
    .TO_W      (13)
  ) dut (
    .clk        (clk),
    .iRst_n     (iRst_n),
    .iStart     (iStart),
    .iAbort     (iAbort),
    .iLayerDone (iLayerDone),
    .iLayerOvf  (iLayerOvf),
    .oLayerEna  (oLayerEna),
    .oLayerRst_n(oLayerRst_n),
    .oSel       (oSel),
    .oBusy      (oBusy),
    .oDone      (oDone),
    .oOverflow  (oOverflow),
    .oTimeout   (oTimeout),
    .oErrLayer  (oErrLayer)
  );

  always #5 clk = ~clk;

  // Layer engines: counts enabled cycles after local reset; done level once count reaches latency.
  initial for (int i = 0; i < N; i++) begin cnt[i] = 0; junk[i] = 1'b0; lat[i] = 1000; ovf_val[i] = 1'b0; end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!oLayerRst_n[i]) cnt[i] <= 0;
      else if (oLayerEna[i] && cnt[i] < 10000) cnt[i] <= cnt[i] + 1;
      junk[i] <= 1'($urandom);
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      iLayerDone[i] = (cnt[i] >= lat[i]);
      iLayerOvf[i]  = oLayerEna[i] ? (iLayerDone[i] ? ovf_val[i] : junk[i]) : 1'bx;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [N-1:0] ena, input logic [N-1:0] rstn, input logic [1:0] sel,
                              input logic busy, input logic done, input logic ovf, input logic to,
                              input logic [1:0] errl);
    vec_t v;
    v.ena = ena; v.rstn = rstn; v.sel = sel; v.busy = busy;
    v.done = done; v.ovf = ovf; v.to = to; v.errl = errl;
    return v;
  endfunction

  function automatic vec_t observed();
    vec_t v;
    v = {oLayerEna, oLayerRst_n, oSel, oBusy, oDone, oOverflow, oTimeout, oErrLayer};
    return v;
  endfunction

  // Expected outputs for each cycle following the start edge, derived from the layers' run lengths.
  task automatic build_trace();
    logic acc;
    logic [N-1:0] one;
    int unsigned r, runc;
    acc = 1'b0;
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      one = N'(1) << i;
      for (int c = 0; c < RC; c++) exp_q.push_back(mk(one, ~one, 2'(i), 1, 0, acc, 0, 0));
      r    = lat[i] + 1;
      runc = (r > TO) ? TO : r;
      for (int unsigned c = 0; c < runc; c++) exp_q.push_back(mk(one, '1, 2'(i), 1, 0, acc, 0, 0));
      if (r > TO) begin
        exp_q.push_back(mk('0, '1, 2'(i), 0, 0, acc, 1, 2'(i)));
        return;
      end
      acc = acc | ovf_val[i];
      exp_q.push_back(mk('0, '1, 2'(i), 1, 0, acc, 0, 0));
    end
    exp_q.push_back(mk('0, '1, 2'(N - 1), 0, 1, acc, 0, 0));
  endtask

  // stop_kind: 0 run to end, 1 abort after cycle stop_at, 2 reset after cycle stop_at.
  task automatic run_seq(input string tag, input int stop_kind, input int stop_at, input int spur_at);
    vec_t e;
    int len, sa, sp;
    build_trace();
    len = exp_q.size();
    sa  = (stop_at > len - 2) ? len - 2 : stop_at;
    sp  = (spur_at > len - 2) ? -1 : spur_at;
    @(negedge clk);
    iStart = 1'b1;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      iStart = 1'b0; iAbort = 1'b0; iRst_n = 1'b1;
      e = exp_q[k];
      check_eq(tag, 32'(observed()), 32'(e));
      if (k == len - 1) break;
      iStart = (k == sp);
      if (stop_kind == 1 && k == sa) begin
        iAbort = 1'b1;
        @(negedge clk);
        iAbort = 1'b0; iStart = 1'b0;
        e = mk('0, '1, e.sel, 0, 0, e.ovf, 0, e.errl);
        check_eq({tag, "_abort"}, 32'(observed()), 32'(e));
        iAbort = 1'b1; iStart = 1'b1;
        @(negedge clk);
        iAbort = 1'b0; iStart = 1'b0;
        check_eq({tag, "_abort_start"}, 32'(observed()), 32'(e));
        return;
      end
      if (stop_kind == 2 && k == sa) begin
        iRst_n = 1'b0;
        @(negedge clk);
        iRst_n = 1'b1; iStart = 1'b0;
        check_eq({tag, "_reset"}, 32'(observed()), 32'(mk('0, '1, 0, 0, 0, 0, 0, 0)));
        return;
      end
    end
    iAbort = 1'($urandom);
    @(negedge clk);
    iAbort = 1'b0;
    check_eq({tag, "_hold"}, 32'(observed()), 32'(exp_q[len - 1]));
  endtask

  initial begin
    iRst_n = 1'b0; iStart = 1'b0; iAbort = 1'b0;
    @(negedge clk);
    iRst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("reset_idle", 32'(observed()), 32'(mk('0, '1, 0, 0, 0, 0, 0, 0)));
    end

    for (int i = 0; i < N; i++) begin lat[i] = 4; ovf_val[i] = 1'b0; end
    run_seq("seq_basic", 0, 0, -1);

    ovf_val[1] = 1'b1;
    run_seq("ovf_l1", 0, 0, -1);

    ovf_val[1] = 1'b0; lat[2] = 100;
    run_seq("timeout_l2", 0, 0, -1);
    lat[2] = 4;
    run_seq("restart_after_err", 0, 0, -1);

    lat[0] = 15; lat[1] = 16;
    run_seq("wdog_edge", 0, 0, -1);
    lat[0] = 4; lat[1] = 4;

    run_seq("abort_l1_run", 1, 11, -1);
    run_seq("reset_l1_run", 2, 12, 10);

    for (int t = 0; t < 30; t++) begin
      int unsigned r, kind;
      for (int i = 0; i < N; i++) begin
        r = $urandom_range(0, 9);
        if (r < 6)       lat[i] = $urandom_range(0, 6);
        else if (r == 6) lat[i] = 15;
        else if (r == 7) lat[i] = 16;
        else if (r == 8) lat[i] = 14;
        else             lat[i] = 40;
        ovf_val[i] = 1'($urandom);
      end
      r    = $urandom_range(0, 9);
      kind = (r < 6) ? 0 : (r < 8) ? 1 : 2;
      run_seq("rand", int'(kind), int'($urandom_range(0, 40)),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
